mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive CPU grants while a debug request waits.
REQ-002 Parameter AW, default 5: address width (32-entry memory).
REQ-003 Parameter DW, default 8: data width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cpu_req  input  1  CPU access request; held with cpu_we, cpu_addr and cpu_wdata stable until cpu_gnt.
REQ-007 cpu_we  input  1  CPU write (1) or read (0).
REQ-008 cpu_addr  input  AW  CPU address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_halt  input  1  CPU in halt state.
REQ-011 cpu_gnt  output  1  CPU access issued this cycle.
REQ-012 cpu_rvalid  output  1  CPU read data valid.
REQ-013 cpu_rdata  output  DW  CPU read data.
REQ-014 dbg_req, dbg_we, dbg_addr[AW], dbg_wdata[DW]  input  debug/loader port, same rules as the CPU port.
REQ-015 dbg_lock  input  1  debug port requests exclusive ownership for a burst.
REQ-016 dbg_gnt, dbg_rvalid (1), dbg_rdata (DW)  output  debug port counterparts of the CPU outputs.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_addr  output  AW  memory address.
REQ-020 mem_wdata  output  DW  memory write data.
REQ-021 mem_rdata  input  DW  memory read data, valid one cycle after an mem_en read.
REQ-022 locked  output  1  FSM is in LOCKED.

Function
REQ-023 Grant decision is combinational in the request cycle; cpu_gnt and dbg_gnt shall never both be 1.
REQ-024 mem_en equals cpu_gnt OR dbg_gnt; mem_we, mem_addr and mem_wdata are muxed from the granted port; with no grant, mem_we=0 and addr/wdata=0.
REQ-025 FSM states ARB and LOCKED.
REQ-026 In ARB with cpu_halt=1, dbg_req wins.
REQ-027 In ARB with cpu_halt=0, cpu_req wins unless starve_cnt==STARVE_MAX and dbg_req=1, in which case dbg wins.
REQ-028 starve_cnt increments when the CPU is granted while dbg_req=1, saturating at STARVE_MAX.
REQ-029 starve_cnt clears when dbg is granted or dbg_req=0.
REQ-030 Transition ARB->LOCKED on a dbg grant with dbg_lock=1.
REQ-031 In LOCKED only the debug port may be granted; cpu_gnt=0 regardless of cpu_req or cpu_halt.
REQ-032 Transition LOCKED->ARB at the first edge with dbg_lock=0; that cycle is still LOCKED (a dbg grant is allowed, no CPU grant).
REQ-033 Read return: one cycle after a granted read (we=0), the granted port's rvalid=1 and rdata=mem_rdata; the other port's rvalid=0 and rdata=0.
REQ-034 Granted writes produce no rvalid.
REQ-035 Back-to-back grants are allowed every cycle; rvalid follows each read in order.
REQ-036 A request deasserted before grant is dropped without side effects.

Reset
REQ-037 While rst=0 at an edge: FSM=ARB, starve_cnt=0, read-return owner cleared, cpu_rvalid=dbg_rvalid=0, rdata=0.
REQ-038 While rst=0, cpu_gnt=dbg_gnt=mem_en=mem_we=0 combinationally.
REQ-039 Reset mid-LOCKED or with a read in flight discards the pending rvalid and returns to ARB.

Verification
REQ-040 Debug burst with dbg_lock=1: writes mem[0]=0xAA, mem[1]=0x0B, mem[10]=0x05 while cpu_req=1 -> dbg_gnt on all 3 cycles, cpu_gnt=0 and locked=1 throughout; after lock drops, the CPU read of addr 0 gets cpu_rvalid with 0xAA one cycle later.
REQ-041 Starvation with STARVE_MAX=4: cpu_req and dbg_req held high, cpu_halt=0 -> CPU granted 4 cycles, dbg granted on the 5th, then CPU again.
REQ-042 cpu_halt=1 with both requesting -> dbg granted immediately; the CPU is granted only after dbg_req drops.
REQ-043 CPU write 0x0F to addr 12, then read addr 12 on the next cycle -> mem_we=1 then 0, cpu_rvalid=1 with 0x0F two cycles after the write grant, dbg_rvalid stays 0.
REQ-044 rst=0 asserted while locked with a dbg read in flight -> next cycle locked=0, dbg_rvalid=0, all grants 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory. The CPU normally wins.
// The debug/loader port wins when the CPU is halted or has been starved, and it
// can lock the memory for an exclusive burst. Read data returns one cycle after
// the grant and is routed back to whichever port issued the read.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_halt,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    // One-hot owner of the read whose data arrives this cycle.
    logic          rd_cpu_q, rd_dbg_q;

    // Grant decision for the current request cycle.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst) begin
            if (state_q == StLocked) begin
                dbg_gnt = dbg_req;
            end else if (dbg_req && (cpu_halt || starve_q == StarveMax)) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else begin
                dbg_gnt = dbg_req;
            end
        end
    end

    // Memory command mux from the granted port; idle bus drives zeros.
    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Lock FSM next state and starvation counter update.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            StArb:    if (dbg_gnt && dbg_lock) state_d = StLocked;
            StLocked: if (!dbg_lock) state_d = StArb;
            default:  state_d = StArb;
        endcase
        if (dbg_gnt || !dbg_req) begin
            starve_d = '0;
        end else if (cpu_gnt && starve_q != StarveMax) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StArb;
            starve_q <= '0;
            rd_cpu_q <= 1'b0;
            rd_dbg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rd_cpu_q <= cpu_gnt & ~cpu_we;
            rd_dbg_q <= dbg_gnt & ~dbg_we;
        end
    end

    assign cpu_rvalid = rd_cpu_q;
    assign cpu_rdata  = rd_cpu_q ? mem_rdata : '0;
    assign dbg_rvalid = rd_dbg_q;
    assign dbg_rdata  = rd_dbg_q ? mem_rdata : '0;
    assign locked     = (state_q == StLocked);

endmodule
